// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Receives PS/2 device frames (start, 8 data bits LSB first, odd parity,
// stop) and tracks the make code of the key currently held down.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, frames with
// even parity over data+parity are rejected. When it is undefined, the parity
// bit is consumed and ignored.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a start bit (falling edge with data low)
// DATA   | shifting in the 8 payload bits, LSB first
// PARITY | consuming the parity bit
// STOP   | judging the stop bit and handing the byte to the decoder

module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data,
  output logic       extended,
  output logic       byte_valid,
  output logic [7:0] raw_byte,
  output logic       frame_err
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  localparam logic [7:0] CODE_EXT = 8'hE0;
  localparam logic [7:0] CODE_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall;

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       parity_good;

  logic       frame_ok;
  logic       frame_bad;

  logic [7:0] data_q, data_d;
  logic       ext_q, ext_d;
  logic [7:0] raw_q, raw_d;
  logic       bv_q, bv_d;
  logic       ferr_q, ferr_d;
  logic       ext_pend_q, ext_pend_d;
  logic       brk_pend_q, brk_pend_d;

  // Synchronise both PS/2 lines into clk and remember the previous clock level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q <= ps2_clk_s;
    end
  end

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = dat_sync_q[SYNC_STAGES-1];
  assign fall       = clk_prev_q & ~ps2_clk_s;

  // Frame abandon timer: cycles since the last falling edge while mid-frame.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q == ST_IDLE) || fall) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign timeout = (state_q != ST_IDLE) && (to_cnt_q == TO_MAX);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; an expired timer wins over a coincident edge.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE:   if (!ps2_data_s) state_d = ST_DATA;
        ST_DATA:   if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        ST_PARITY: state_d = ST_STOP;
        ST_STOP:   state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Bit counter and shift register advance on sampled edges only.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (fall && !timeout) begin
      unique case (state_q)
        ST_IDLE: bit_cnt_d = 3'd0;
        ST_DATA: begin
          shift_d   = {ps2_data_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  logic parity_q, parity_d;

  // Parity bit capture, only kept when it is actually judged.
  always_comb begin
    parity_d = parity_q;
    if (fall && !timeout && (state_q == ST_PARITY)) begin
      parity_d = ps2_data_s;
    end
  end

  // Parity register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign parity_good = ^{shift_q, parity_q};
`else
  assign parity_good = 1'b1;
`endif

  // FSM outputs: frame verdicts, asserted in the cycle of the deciding event.
  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = 1'b0;
    if (timeout) begin
      frame_bad = 1'b1;
    end else if (fall) begin
      unique case (state_q)
        ST_IDLE: if (ps2_data_s) frame_bad = 1'b1;
        ST_STOP: begin
          if (ps2_data_s && parity_good) frame_ok  = 1'b1;
          else                           frame_bad = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Key tracking: prefix bytes arm flags, other bytes press or release a key.
  always_comb begin
    data_d     = data_q;
    ext_d      = ext_q;
    raw_d      = raw_q;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    bv_d       = frame_ok;
    ferr_d     = frame_bad;
    if (frame_ok) begin
      raw_d = shift_q;
      if (shift_q == CODE_EXT) begin
        ext_pend_d = 1'b1;
      end else if (shift_q == CODE_BRK) begin
        brk_pend_d = 1'b1;
      end else begin
        if (!brk_pend_q) begin
          data_d = shift_q;
          ext_d  = ext_pend_q;
        end else if ((shift_q == data_q) && (ext_pend_q == ext_q)) begin
          data_d = 8'h00;
          ext_d  = 1'b0;
        end
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end
    end else if (frame_bad) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q   <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      data_q     <= 8'h00;
      ext_q      <= 1'b0;
      raw_q      <= 8'h00;
      bv_q       <= 1'b0;
      ferr_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      to_cnt_q   <= to_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_q     <= data_d;
      ext_q      <= ext_d;
      raw_q      <= raw_d;
      bv_q       <= bv_d;
      ferr_q     <= ferr_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  assign data       = data_q;
  assign extended   = ext_q;
  assign raw_byte   = raw_q;
  assign byte_valid = bv_q;
  assign frame_err  = ferr_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed PS/2 frames, a key-tracking model and
// an every-cycle output compare, plus literal expectations at milestones.
`timescale 1ns/1ps

module tb_ps2_key_decoder;

  localparam int TO   = 300;
  localparam int SYNC = 2;
  localparam int H    = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] data;
  logic       extended;
  logic       byte_valid;
  logic [7:0] raw_byte;
  logic       frame_err;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data       (data),
    .extended   (extended),
    .byte_valid (byte_valid),
    .raw_byte   (raw_byte),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int last_fall = 0;
  bit chk_en = 1'b0;

  typedef struct {
    bit         acc;
    logic [7:0] b;
    int         lo;
    int         hi;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  // Specification-level key model.
  logic [7:0] m_data, m_raw;
  logic       m_ext, m_extp, m_brkp;

  task automatic model_reset();
    m_data = 8'h00; m_raw = 8'h00; m_ext = 1'b0; m_extp = 1'b0; m_brkp = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    m_raw = b;
    if (b == 8'hE0) m_extp = 1'b1;
    else if (b == 8'hF0) m_brkp = 1'b1;
    else begin
      if (!m_brkp) begin
        m_data = b; m_ext = m_extp;
      end else if (b == m_data && m_extp == m_ext) begin
        m_data = 8'h00; m_ext = 1'b0;
      end
      m_extp = 1'b0; m_brkp = 1'b0;
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b, required %0b (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Every-cycle compare of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      if (byte_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: byte_valid=%0b frame_err=%0b, required none (cycle %0d)",
                   byte_valid, frame_err, cyc);
        end else begin
          e = exp_q.pop_front();
          chk1("pulse_byte_valid", byte_valid, e.acc);
          chk1("pulse_frame_err", frame_err, !e.acc);
          checks++;
          if (cyc < e.lo || cyc > e.hi) begin
            errors++;
            $display("FAIL pulse_cycle: got %0d, required %0d..%0d", cyc, e.lo, e.hi);
          end
          if (byte_valid) begin
            bv_cnt++;
            model_byte(e.b);
          end else begin
            m_extp = 1'b0; m_brkp = 1'b0;
          end
        end
      end
      chk8("data", data, m_data);
      chk1("extended", extended, m_ext);
      chk8("raw_byte", raw_byte, m_raw);
    end
  end

  // Drive n bits (bits[0] first) as PS/2 clock periods; optionally expect a verdict.
  task automatic send_bits(input logic [10:0] bits, input int n, input bit expect_v,
                           input bit acc, input logic [7:0] b);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (i == n - 1 && expect_v) begin
        x.acc = acc; x.b = b; x.lo = cyc + SYNC + 1; x.hi = cyc + SYNC + 1;
        exp_q.push_back(x);
      end
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (H) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit stop);
    logic par;
    bit   good;
    par = ~(^b) ^ flip_par;
`ifdef PS2_PARITY_CHECK_EN
    good = stop && !flip_par;
`else
    good = stop;
`endif
    send_bits({stop, par, b, 1'b0}, 11, 1'b1, good, b);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL verdict_wait: %0d frame verdicts outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    #1;
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
    wait_idle();
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv0;
    exp_t x;
    model_reset();
    repeat (3) @(negedge clk);
    chk8("reset_data", data, 8'h00);
    chk1("reset_extended", extended, 1'b0);
    chk8("reset_raw", raw_byte, 8'h00);
    chk1("reset_byte_valid", byte_valid, 1'b0);
    chk1("reset_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;

    // Single make code.
    bv0 = bv_cnt;
    good(8'h75);
    chk8("lit_75_data", data, 8'h75);
    chk8("lit_75_raw", raw_byte, 8'h75);
    chk1("lit_75_ext", extended, 1'b0);
    // Release of that key.
    good(8'hF0);
    chk8("lit_brk_prefix_data", data, 8'h75);
    good(8'h75);
    chk8("lit_75_release", data, 8'h00);
    chk8("lit_3_pulses", 8'(bv_cnt - bv0), 8'd3);

    // Extended key, typematic repeat, mismatching breaks, then real release.
    good(8'hE0); good(8'h72);
    chk8("lit_e072_data", data, 8'h72);
    chk1("lit_e072_ext", extended, 1'b1);
    bv0 = bv_cnt;
    good(8'hE0); good(8'h72);
    chk8("lit_repeat_data", data, 8'h72);
    chk8("lit_repeat_pulses", 8'(bv_cnt - bv0), 8'd2);
    good(8'hF0); good(8'h75);
    chk8("lit_other_break", data, 8'h72);
    good(8'hF0); good(8'h72);
    chk1("lit_nonext_break", extended, 1'b1);
    good(8'hE0); good(8'hF0); good(8'h72);
    chk8("lit_ext_release_data", data, 8'h00);
    chk1("lit_ext_release_ext", extended, 1'b0);

    // Inverted parity.
    send_frame(8'h72, 1'b1, 1'b1);
    wait_idle();
`ifdef PS2_PARITY_CHECK_EN
    chk8("lit_badpar_data", data, 8'h00);
`else
    chk8("lit_badpar_data", data, 8'h72);
`endif

    // Bad stop bit, then a stray edge with data high in IDLE.
    good(8'h75);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_idle();
    chk8("lit_badstop_data", data, 8'h75);
    chk8("lit_badstop_raw", raw_byte, 8'h75);
    send_bits(11'h001, 1, 1'b1, 1'b0, 8'h00);
    wait_idle();

    // A rejected frame discards a pending E0.
    good(8'hE0);
    send_frame(8'h33, 1'b0, 1'b0);
    wait_idle();
    good(8'h6B);
    chk8("lit_pend_clear_data", data, 8'h6B);
    chk1("lit_pend_clear_ext", extended, 1'b0);

    // Frame abandoned after 4 data bits.
    send_bits({6'b0, 4'b0101, 1'b0}, 5, 1'b0, 1'b0, 8'h00);
    x.acc = 1'b0; x.b = 8'h00; x.lo = last_fall + TO; x.hi = last_fall + TO + SYNC + 4;
    exp_q.push_back(x);
    wait_idle();
    good(8'h72);
    chk8("lit_after_timeout", data, 8'h72);

    // Reset in the middle of a frame after 5 data bits.
    good(8'h75);
    send_bits({5'b0, 5'b10101, 1'b0}, 6, 1'b0, 1'b0, 8'h00);
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk8("lit_midreset_data", data, 8'h00);
    chk8("lit_midreset_raw", raw_byte, 8'h00);
    chk1("lit_midreset_ext", extended, 1'b0);
    chk1("lit_midreset_bv", byte_valid, 1'b0);
    chk1("lit_midreset_ferr", frame_err, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    chk_en = 1'b1;
    good(8'h75);
    chk8("lit_post_reset_data", data, 8'h75);
    chk8("lit_post_reset_raw", raw_byte, 8'h75);

    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
